// File: rtl/gen_phv_multiport.sv
// Multi-channel packet header vector generator: round-robin grant across
// packet inputs, header capture into a PHV FIFO, config-packet rule writes.
module gen_phv_multiport #(
  parameter int          N_PORTS    = 2,
  parameter int          HEAD_BEATS = 4,
  parameter int          PHV_DEPTH  = 4,
  parameter logic [15:0] CONF_ETYPE = 16'h9006
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_PORTS-1:0]        i_pkt_valid,
  input  logic [N_PORTS*134-1:0]    i_pkt,
  output logic [N_PORTS-1:0]        o_pkt_ready,
  output logic                      o_phv_valid,
  input  logic                      i_phv_ready,
  output logic [HEAD_BEATS*128-1:0] o_phv,
  output logic [15:0]               o_meta,
  output logic                      o_rule_wren,
  output logic [31:0]               o_rule_addr,
  output logic [31:0]               o_rule_wdata,
  output logic [15:0]               o_drop_cnt
);
  localparam int HW = HEAD_BEATS * 128;
  localparam int CW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int AW = $clog2(PHV_DEPTH);
  localparam int EW = HW + 16;

  typedef enum logic [1:0] {IDLE, COLLECT, CONF, DISCARD} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_gnt, r_last, w_next;
  logic [N_PORTS-1:0] r_ready;
  logic               r_first;
  logic [7:0]         r_cnt;
  logic [HW-1:0]      r_buf;
  logic               r_push_pend;
  logic               r_wren;
  logic [31:0]        r_raddr, r_rdata;
  logic [15:0]        r_drop;
  logic [EW-1:0]      r_mem [PHV_DEPTH];
  logic [AW-1:0]      r_wr, r_rd;
  logic [AW:0]        r_occ;

  logic [133:0]  w_beat;
  logic [1:0]    w_tag;
  logic [127:0]  w_data;
  logic          w_acc, w_start, w_tail, w_isconf, w_found;
  logic          w_disc, w_col_tail, w_pop, w_push, w_full_drop;
  logic [EW-1:0] w_head;

  // First valid channel strictly after the last granted one, wrapping.
  always_comb begin
    w_next  = r_last;
    w_found = 1'b0;
    for (int i = 1; i <= N_PORTS; i++) begin
      if (!w_found && i_pkt_valid[(int'(r_last) + i) % N_PORTS]) begin
        w_found = 1'b1;
        w_next  = CW'((int'(r_last) + i) % N_PORTS);
      end
    end
  end

  assign w_beat   = i_pkt[r_gnt*134 +: 134];
  assign w_tag    = w_beat[133:132];
  assign w_data   = w_beat[127:0];
  assign w_start  = w_tag[0];
  assign w_tail   = w_tag[1];
  assign w_isconf = (w_data[31:16] == CONF_ETYPE);
  assign w_acc    = |(i_pkt_valid & r_ready);

  assign w_disc      = w_acc & r_first & ~w_start;
  assign w_col_tail  = w_acc & w_tail &
                       (r_first ? (w_start & ~w_isconf) : (r_state == COLLECT));
  assign w_pop       = (r_occ != '0) & i_phv_ready;
  assign w_push      = r_push_pend & ((r_occ < (AW+1)'(PHV_DEPTH)) | w_pop);
  assign w_full_drop = r_push_pend & ~w_push;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_last      <= CW'(N_PORTS - 1);
      r_gnt       <= '0;
      r_ready     <= '0;
      r_first     <= 1'b0;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_push_pend <= 1'b0;
      r_wren      <= 1'b0;
      r_raddr     <= '0;
      r_rdata     <= '0;
      r_drop      <= '0;
    end else begin
      r_wren      <= 1'b0;
      r_push_pend <= w_col_tail;
      if ((w_disc | w_full_drop) && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      case (r_state)
        IDLE: begin
          if (|i_pkt_valid) begin
            r_gnt   <= w_next;
            r_last  <= w_next;
            r_ready <= N_PORTS'(1) << w_next;
            r_first <= 1'b1;
            r_state <= COLLECT;
          end
        end
        default: begin
          if (w_acc) begin
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            if (r_first) begin
              // The first beat decides what this packet is.
              r_first <= 1'b0;
              r_cnt   <= 8'd1;
              if (!w_start) r_state <= DISCARD;
              else if (w_isconf) r_state <= CONF;
              else begin
                r_state <= COLLECT;
                for (int s = 0; s < HEAD_BEATS; s++)
                  r_buf[HW-1-128*s -: 128] <= (s == 0) ? w_data : 128'h0;
              end
            end else if (r_state == COLLECT) begin
              for (int s = 0; s < HEAD_BEATS; s++)
                if (int'(r_cnt) == s) r_buf[HW-1-128*s -: 128] <= w_data;
            end else if (r_state == CONF) begin
              r_wren  <= 1'b1;
              r_raddr <= w_data[47:16];
              r_rdata <= w_data[79:48];
            end
            if (w_tail) begin
              r_ready <= '0;
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // r_buf, r_cnt and r_gnt still hold the finished packet one cycle after its tail.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= {r_buf, r_cnt, 8'(r_gnt)};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign w_head       = r_mem[r_rd];
  assign o_phv_valid  = (r_occ != '0);
  assign o_phv        = o_phv_valid ? w_head[EW-1:16] : '0;
  assign o_meta       = o_phv_valid ? w_head[15:0] : 16'h0;
  assign o_pkt_ready  = r_ready;
  assign o_rule_wren  = r_wren;
  assign o_rule_addr  = r_raddr;
  assign o_rule_wdata = r_rdata;
  assign o_drop_cnt   = r_drop;
endmodule

// File: tb/tb_gen_phv_multiport.sv
// Directed bench for gen_phv_multiport with default parameters (2 ports, 4 head beats, depth 4).
module tb_gen_phv_multiport;
  logic         clk = 1'b0;
  logic         i_rst;
  logic [1:0]   i_pkt_valid;
  logic [267:0] i_pkt;
  logic [1:0]   o_pkt_ready;
  logic         o_phv_valid;
  logic         i_phv_ready;
  logic [511:0] o_phv;
  logic [15:0]  o_meta;
  logic         o_rule_wren;
  logic [31:0]  o_rule_addr, o_rule_wdata;
  logic [15:0]  o_drop_cnt;

  int asserts = 0;
  int fails   = 0;
  logic [133:0] bq [8];
  int n_wr = 0;
  logic [31:0] la [16];
  logic [31:0] ld [16];

  gen_phv_multiport dut (
    .i_clk(clk), .i_rst(i_rst), .i_pkt_valid(i_pkt_valid), .i_pkt(i_pkt),
    .o_pkt_ready(o_pkt_ready), .o_phv_valid(o_phv_valid), .i_phv_ready(i_phv_ready),
    .o_phv(o_phv), .o_meta(o_meta), .o_rule_wren(o_rule_wren),
    .o_rule_addr(o_rule_addr), .o_rule_wdata(o_rule_wdata), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_rule_wren) begin
      if (n_wr < 16) begin
        la[n_wr] = o_rule_addr;
        ld[n_wr] = o_rule_wdata;
      end
      n_wr++;
    end
  end

  function automatic logic [133:0] bt(input logic [1:0] t, input logic [127:0] d);
    return {t, 4'h0, d};
  endfunction

  function automatic logic [127:0] dat(input int k);
    return {4{24'hD00D00, 8'(k)}};
  endfunction

  task automatic do_reset();
    i_rst = 1'b1;
    i_pkt_valid = '0;
    i_phv_ready = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic wait_ready(input int c);
    int n = 0;
    while (!o_pkt_ready[c] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_pkt_ready[c]) begin
      asserts++; fails++;
      $display("FAIL ready_timeout ch%0d: ready=%b required 1", c, o_pkt_ready[c]);
    end
  endtask

  task automatic send(input int c, input int nb);
    for (int b = 0; b < nb; b++) begin
      i_pkt[c*134 +: 134] = bq[b];
      i_pkt_valid[c] = 1'b1;
      wait_ready(c);
      @(negedge clk);
    end
    i_pkt_valid[c] = 1'b0;
  endtask

  task automatic pop();
    i_phv_ready = 1'b1;
    @(negedge clk);
    i_phv_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_pkt = '0;
    do_reset();
    asserts += 6;
    if (o_pkt_ready !== 2'b00) begin fails++; $display("FAIL rst_ready: got %b required 00", o_pkt_ready); end
    if (o_phv_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b required 0", o_phv_valid); end
    if (o_rule_wren !== 1'b0) begin fails++; $display("FAIL rst_wren: got %b required 0", o_rule_wren); end
    if (o_drop_cnt !== 16'h0) begin fails++; $display("FAIL rst_drop: got %h required 0", o_drop_cnt); end
    if (o_meta !== 16'h0) begin fails++; $display("FAIL rst_meta: got %h required 0", o_meta); end
    if (o_phv !== 512'h0) begin fails++; $display("FAIL rst_phv: got %h required 0", o_phv); end
  endtask

  task automatic test_basic();
    logic [511:0] exp_phv;
    bq[0] = bt(2'b01, dat(0)); bq[1] = bt(2'b00, dat(1)); bq[2] = bt(2'b10, dat(2));
    send(0, 3);
    asserts++;
    if (o_phv_valid !== 1'b0) begin fails++; $display("FAIL lat_t1: valid=%b required 0", o_phv_valid); end
    @(negedge clk);
    asserts++;
    if (o_phv_valid !== 1'b1) begin fails++; $display("FAIL lat_t2: valid=%b required 1", o_phv_valid); end
    exp_phv = {dat(0), dat(1), dat(2), 128'h0};
    asserts += 2;
    if (o_phv !== exp_phv) begin fails++; $display("FAIL basic_phv: got %h required %h", o_phv, exp_phv); end
    if (o_meta !== 16'h0300) begin fails++; $display("FAIL basic_meta: got %h required 0300", o_meta); end
    pop();
    asserts++;
    if (o_phv_valid !== 1'b0) begin fails++; $display("FAIL basic_pop: valid=%b required 0", o_phv_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    i_pkt[0 +: 134]   = bt(2'b11, dat(5));
    i_pkt[134 +: 134] = bt(2'b11, dat(6));
    i_pkt_valid = 2'b11;
    wait_ready(0);
    asserts++;
    if (o_pkt_ready !== 2'b01) begin fails++; $display("FAIL rr_first_grant: got %b required 01", o_pkt_ready); end
    @(negedge clk);
    i_pkt_valid[0] = 1'b0;
    wait_ready(1);
    @(negedge clk);
    i_pkt_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    asserts += 4;
    if (o_meta !== 16'h0100) begin fails++; $display("FAIL rr_meta0: got %h required 0100", o_meta); end
    if (o_phv[511:384] !== dat(5)) begin fails++; $display("FAIL rr_phv0: got %h required %h", o_phv[511:384], dat(5)); end
    pop();
    if (o_meta !== 16'h0101) begin fails++; $display("FAIL rr_meta1: got %h required 0101", o_meta); end
    if (o_phv[511:384] !== dat(6)) begin fails++; $display("FAIL rr_phv1: got %h required %h", o_phv[511:384], dat(6)); end
    pop();
  endtask

  task automatic test_conf();
    int b0;
    b0 = n_wr;
    bq[0] = bt(2'b01, {96'h0, 16'h9006, 16'h0});
    bq[1] = bt(2'b00, {48'h0, 32'hDEADBEEF, 32'h00000010, 16'h0});
    bq[2] = bt(2'b10, {48'h0, 32'hCAFEF00D, 32'h00000014, 16'h0});
    send(0, 3);
    repeat (3) @(negedge clk);
    asserts += 6;
    if (n_wr - b0 !== 2) begin fails++; $display("FAIL conf_pulses: got %0d required 2", n_wr - b0); end
    if (la[b0] !== 32'h10) begin fails++; $display("FAIL conf_addr0: got %h required 00000010", la[b0]); end
    if (ld[b0] !== 32'hDEADBEEF) begin fails++; $display("FAIL conf_data0: got %h required deadbeef", ld[b0]); end
    if (la[b0+1] !== 32'h14) begin fails++; $display("FAIL conf_addr1: got %h required 00000014", la[b0+1]); end
    if (ld[b0+1] !== 32'hCAFEF00D) begin fails++; $display("FAIL conf_data1: got %h required cafef00d", ld[b0+1]); end
    if (o_phv_valid !== 1'b0) begin fails++; $display("FAIL conf_nophv: valid=%b required 0", o_phv_valid); end
  endtask

  task automatic test_fifo_full();
    i_phv_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bq[0] = bt(2'b11, dat(16 + i));
      send(0, 1);
    end
    repeat (3) @(negedge clk);
    asserts += 2;
    if (o_drop_cnt !== 16'd1) begin fails++; $display("FAIL full_drop: got %0d required 1", o_drop_cnt); end
    if (o_phv_valid !== 1'b1) begin fails++; $display("FAIL full_valid: valid=%b required 1", o_phv_valid); end
    for (int i = 0; i < 4; i++) begin
      asserts += 2;
      if (o_meta !== 16'h0100) begin fails++; $display("FAIL full_meta%0d: got %h required 0100", i, o_meta); end
      if (o_phv[511:384] !== dat(16 + i)) begin
        fails++; $display("FAIL full_order%0d: got %h required %h", i, o_phv[511:384], dat(16 + i));
      end
      pop();
    end
    asserts++;
    if (o_phv_valid !== 1'b0) begin fails++; $display("FAIL full_empty: valid=%b required 0", o_phv_valid); end
  endtask

  task automatic test_discard();
    do_reset();
    bq[0] = bt(2'b00, dat(1)); bq[1] = bt(2'b00, dat(2)); bq[2] = bt(2'b10, dat(3));
    send(0, 3);
    repeat (3) @(negedge clk);
    asserts += 2;
    if (o_drop_cnt !== 16'd1) begin fails++; $display("FAIL disc_drop: got %0d required 1", o_drop_cnt); end
    if (o_phv_valid !== 1'b0) begin fails++; $display("FAIL disc_nophv: valid=%b required 0", o_phv_valid); end
    bq[0] = bt(2'b01, dat(7)); bq[1] = bt(2'b10, dat(8));
    send(1, 2);
    repeat (2) @(negedge clk);
    asserts += 3;
    if (o_phv !== {dat(7), dat(8), 256'h0}) begin fails++; $display("FAIL disc_next_phv: got %h", o_phv); end
    if (o_meta !== 16'h0201) begin fails++; $display("FAIL disc_next_meta: got %h required 0201", o_meta); end
    if (o_drop_cnt !== 16'd1) begin fails++; $display("FAIL disc_drop_hold: got %0d required 1", o_drop_cnt); end
    pop();
  endtask

  task automatic test_reset_mid();
    bq[0] = bt(2'b01, dat(11)); bq[1] = bt(2'b00, dat(12));
    send(0, 2);
    i_pkt[0 +: 134] = bt(2'b00, dat(13));
    i_pkt_valid[0] = 1'b1;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    i_pkt_valid = '0;
    asserts += 5;
    if (o_pkt_ready !== 2'b00) begin fails++; $display("FAIL mid_ready: got %b required 00", o_pkt_ready); end
    if (o_phv_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b required 0", o_phv_valid); end
    if (o_drop_cnt !== 16'h0) begin fails++; $display("FAIL mid_drop: got %h required 0", o_drop_cnt); end
    if (o_meta !== 16'h0) begin fails++; $display("FAIL mid_meta: got %h required 0", o_meta); end
    if (o_rule_wren !== 1'b0) begin fails++; $display("FAIL mid_wren: got %b required 0", o_rule_wren); end
    repeat (3) @(negedge clk);
    asserts++;
    if (o_phv_valid !== 1'b0) begin fails++; $display("FAIL mid_nopush: valid=%b required 0", o_phv_valid); end
    bq[0] = bt(2'b01, dat(9)); bq[1] = bt(2'b10, dat(10));
    send(0, 2);
    repeat (2) @(negedge clk);
    asserts += 3;
    if (o_phv !== {dat(9), dat(10), 256'h0}) begin fails++; $display("FAIL mid_next_phv: got %h", o_phv); end
    if (o_meta !== 16'h0200) begin fails++; $display("FAIL mid_next_meta: got %h required 0200", o_meta); end
    if (o_drop_cnt !== 16'h0) begin fails++; $display("FAIL mid_next_drop: got %h required 0", o_drop_cnt); end
    pop();
  endtask

  initial begin
    i_rst = 1'b1;
    i_pkt_valid = '0;
    i_phv_ready = 1'b0;
    i_pkt = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_round_robin();
    test_conf();
    test_fifo_full();
    test_discard();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
